// File: rtl/tone_scheduler.sv
// Tone scheduler: grants one of four arrow pads (round-robin) or the song sequencer to the single
// square-wave tone generator, enforcing a minimum note length and a silent gap between notes.
// Optional feature macro: TONE_SCHED_PREEMPT_EN (a pad press aborts a playing sequencer note).
module tone_scheduler #(
    parameter int unsigned NOTE_TICKS = 10000000,
    parameter int unsigned GAP_TICKS  = 1000000,
    parameter logic [28:0] HP0        = 29'd95555,
    parameter logic [28:0] HP1        = 29'd75842,
    parameter logic [28:0] HP2        = 29'd63775,
    parameter logic [28:0] HP3        = 29'd47777
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  pad_req,
    input  logic        seq_valid,
    input  logic [28:0] seq_freq,
    output logic        seq_ready,
    output logic [28:0] frequency,
    output logic        tone_en,
    output logic        busy,
    output logic [2:0]  active_src
);

    localparam int unsigned CNT_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int          CW      = $clog2(CNT_MAX + 32'd1);
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_TICKS - 32'd1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 32'd1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
    localparam logic [2:0]    SRC_SEQ   = 3'd4;
    localparam logic [2:0]    SRC_NONE  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [28:0]   frequency_q, frequency_d;
    logic          tone_en_q, tone_en_d;
    logic [2:0]    active_src_q, active_src_d;
    logic          busy_q, busy_d;

    logic [1:0]    win_s;
    logic          pad_held_s;
    logic          note_done_s;
    logic          preempt_s;

    // Round-robin pick: the search starts one past the last winner and wraps.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    function automatic logic [28:0] pad_hp(input logic [1:0] idx);
        logic [28:0] hp;
        case (idx)
            2'd0:    hp = HP0;
            2'd1:    hp = HP1;
            2'd2:    hp = HP2;
            2'd3:    hp = HP3;
            default: hp = HP0;
        endcase
        return hp;
    endfunction

    assign win_s       = rr_pick(pad_req, ptr_q);
    assign pad_held_s  = (active_src_q != SRC_SEQ) && pad_req[active_src_q[1:0]];
    assign note_done_s = (cnt_q == NOTE_LAST) && !pad_held_s;

`ifdef TONE_SCHED_PREEMPT_EN
    assign preempt_s = (active_src_q == SRC_SEQ) && (pad_req != 4'd0);
`else
    assign preempt_s = 1'b0;
`endif

    // Handshake is only offered when no pad would win the same IDLE edge.
    assign seq_ready = (state_q == ST_IDLE) && seq_valid && (pad_req == 4'd0);

    // Next-state and next-output computation for the grant / play / gap sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        frequency_d  = frequency_q;
        tone_en_d    = tone_en_q;
        active_src_d = active_src_q;
        case (state_q)
            ST_IDLE: begin
                if (pad_req != 4'd0) begin
                    ptr_d        = win_s;
                    frequency_d  = pad_hp(win_s);
                    tone_en_d    = 1'b1;
                    active_src_d = {1'b0, win_s};
                    cnt_d        = '0;
                    state_d      = ST_PLAY;
                end else if (seq_valid) begin
                    frequency_d  = seq_freq;
                    tone_en_d    = 1'b1;
                    active_src_d = SRC_SEQ;
                    cnt_d        = '0;
                    state_d      = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (preempt_s || note_done_s) begin
                    tone_en_d    = 1'b0;
                    active_src_d = SRC_NONE;
                    cnt_d        = '0;
                    state_d      = ST_GAP;
                end else if (cnt_q == NOTE_LAST) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cnt_d        = '0;
                tone_en_d    = 1'b0;
                active_src_d = SRC_NONE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset silences the speaker immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= 2'd3;
            frequency_q  <= 29'd0;
            tone_en_q    <= 1'b0;
            active_src_q <= SRC_NONE;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            frequency_q  <= frequency_d;
            tone_en_q    <= tone_en_d;
            active_src_q <= active_src_d;
            busy_q       <= busy_d;
        end
    end

    assign frequency  = frequency_q;
    assign tone_en    = tone_en_q;
    assign active_src = active_src_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: a note-level reference model compared every cycle,
// plus directed scenarios whose note lengths, pitches, sources and gaps are pinned by literals.
module tb_tone_scheduler;

    localparam int NT = 8;
    localparam int GT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pad_req = 4'd0;
    logic        seq_valid = 1'b0;
    logic [28:0] seq_freq = 29'd0;
    logic        seq_ready;
    logic [28:0] frequency;
    logic        tone_en;
    logic        busy;
    logic [2:0]  active_src;

    int checks = 0;
    int failures = 0;

    tone_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .CLK(clk), .RST_N(rst_n), .pad_req(pad_req), .seq_valid(seq_valid),
        .seq_freq(seq_freq), .seq_ready(seq_ready), .frequency(frequency),
        .tone_en(tone_en), .busy(busy), .active_src(active_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Reference model: a note lasts at least NT cycles, a pad note as long as its pad is held,
    // then GT silent cycles; pads beat the sequencer and rotate fairly.
    logic        m_playing;
    int          m_gap_left;
    int          m_played;
    int          m_last_pad;
    logic [2:0]  m_src;
    logic [28:0] m_freq;
    int          hp_tab[4] = '{95555, 75842, 63775, 47777};

    always @(posedge clk or negedge rst_n) begin
        int  win;
        bit  found;
        bit  preempt;
        if (!rst_n) begin
            m_playing = 1'b0; m_gap_left = 0; m_played = 0; m_last_pad = 3;
            m_src = 3'd7; m_freq = 29'd0;
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_playing) begin
            m_played++;
            preempt = 1'b0;
`ifdef TONE_SCHED_PREEMPT_EN
            preempt = (m_src == 3'd4) && (pad_req != 4'd0);
`endif
            if (preempt || (m_played >= NT && (m_src == 3'd4 || !pad_req[m_src[1:0]]))) begin
                m_playing = 1'b0; m_src = 3'd7; m_gap_left = GT;
            end
        end else if (pad_req != 4'd0) begin
            found = 1'b0; win = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && pad_req[(m_last_pad + k) % 4]) begin
                    win = (m_last_pad + k) % 4; found = 1'b1;
                end
            end
            m_last_pad = win; m_playing = 1'b1; m_played = 0;
            m_src = 3'(win); m_freq = 29'(hp_tab[win]);
        end else if (seq_valid) begin
            m_playing = 1'b1; m_played = 0; m_src = 3'd4; m_freq = seq_freq;
        end
    end

    // Per-cycle comparison against the model, plus a run-length recorder of notes and gaps.
    int len_q[$];
    int freq_q[$];
    int src_q[$];
    int gap_q[$];
    int run_len = 0;
    int gap_len = 0;
    int last_freq = 0;
    int last_src = 0;
    int accepts = 0;

    always @(posedge clk) begin
        if (seq_valid && seq_ready) accepts++;
    end

    always @(posedge clk) begin
        logic exp_busy;
        logic exp_ready;
        #2;
        exp_busy  = m_playing || (m_gap_left > 0);
        exp_ready = !exp_busy && seq_valid && (pad_req == 4'd0);
        checks++;
        if ({frequency, tone_en, active_src, busy, seq_ready} !==
            {m_freq, m_playing, m_src, exp_busy, exp_ready}) begin
            failures++;
            $display("FAIL cycle_model t=%0t: got freq=%0d tone=%0b src=%0d busy=%0b ready=%0b required freq=%0d tone=%0b src=%0d busy=%0b ready=%0b",
                     $time, frequency, tone_en, active_src, busy, seq_ready,
                     m_freq, m_playing, m_src, exp_busy, exp_ready);
        end
        if (!rst_n) begin
            run_len = 0; gap_len = 0;
        end else begin
            if (tone_en) begin
                run_len++; last_freq = int'(frequency); last_src = int'(active_src);
            end else if (run_len > 0) begin
                len_q.push_back(run_len); freq_q.push_back(last_freq); src_q.push_back(last_src);
                run_len = 0;
            end
            if (busy && !tone_en) gap_len++;
            else if (gap_len > 0) begin
                gap_q.push_back(gap_len); gap_len = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int c;
        c = 0;
        step(1);
        while ((busy || tone_en) && c < budget) begin
            step(1); c++;
        end
        if (busy || tone_en) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got busy=%0b required busy=0 within %0d cycles", nm, busy, budget);
        end
    endtask

    task automatic chk_note(input string nm, input int idx, input int el, input int ef, input int es);
        if (idx < len_q.size()) begin
            chk({nm, "_len"}, 32'(len_q[idx]), 32'(el));
            chk({nm, "_freq"}, 32'(freq_q[idx]), 32'(ef));
            chk({nm, "_src"}, 32'(src_q[idx]), 32'(es));
        end else begin
            checks++; failures++;
            $display("FAIL %s_missing: got %0d notes required index %0d", nm, len_q.size(), idx);
        end
    endtask

    task automatic chk_gap(input string nm, input int idx);
        if (idx < gap_q.size()) chk(nm, 32'(gap_q[idx]), 32'(GT));
        else begin
            checks++; failures++;
            $display("FAIL %s_missing: got %0d gaps required index %0d", nm, gap_q.size(), idx);
        end
    endtask

    initial begin
        int nb;
        int gb;
        int ab;
        int c;

        // Reset state
        step(3);
        rst_n = 1'b1;
        step(2);
        chk("rst_freq", 32'(frequency), 32'd0);
        chk("rst_tone", 32'(tone_en), 32'd0);
        chk("rst_src", 32'(active_src), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(seq_ready), 32'd0);

        // Single-cycle press of pad 0
        nb = len_q.size(); gb = gap_q.size();
        pad_req = 4'b0001; step(1); pad_req = 4'b0000;
        chk("p0_freq_now", 32'(frequency), 32'd95555);
        chk("p0_tone_now", 32'(tone_en), 32'd1);
        wait_idle("p0", 40);
        chk_note("p0", nb, 8, 95555, 0);
        chk_gap("p0_gap", gb);

        // Pad 2 held 20 cycles
        nb = len_q.size(); gb = gap_q.size();
        pad_req = 4'b0100; step(20); pad_req = 4'b0000;
        wait_idle("p2", 60);
        chk_note("p2", nb, 20, 63775, 2);
        chk_gap("p2_gap", gb);

        // Reset in mid-note drops the tone without a clock edge
        pad_req = 4'b0010; step(1); pad_req = 4'b0000; step(2);
        chk("pre_rst_tone", 32'(tone_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tone", 32'(tone_en), 32'd0);
        chk("async_rst_src", 32'(active_src), 32'd7);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1; step(2);

        // All pads requesting: round-robin 0,1,2,3,0
        nb = len_q.size(); gb = gap_q.size();
        c = 0;
        while (len_q.size() < nb + 5 && c < 300) begin
            pad_req = (tone_en && active_src < 3'd4) ? (4'hF & ~(4'b0001 << active_src[1:0])) : 4'hF;
            step(1); c++;
        end
        pad_req = 4'b0000;
        wait_idle("rr", 40);
        chk_note("rr0", nb,     8, 95555, 0);
        chk_note("rr1", nb + 1, 8, 75842, 1);
        chk_note("rr2", nb + 2, 8, 63775, 2);
        chk_note("rr3", nb + 3, 8, 47777, 3);
        chk_note("rr4", nb + 4, 8, 95555, 0);
        chk_gap("rr_gap0", gb);
        chk_gap("rr_gap4", gb + 4);

        // Sequencer note alone
        nb = len_q.size(); ab = accepts;
        seq_valid = 1'b1; seq_freq = 29'd12345;
        #1;
        chk("seq_ready_idle", 32'(seq_ready), 32'd1);
        step(1); seq_valid = 1'b0;
        chk("seq_freq_now", 32'(frequency), 32'd12345);
        wait_idle("seq", 40);
        chk_note("seq", nb, 8, 12345, 4);
        chk("seq_accepts", 32'(accepts - ab), 32'd1);

        // Pad and sequencer together: pad first, then sequencer after the gap
        nb = len_q.size(); ab = accepts;
        seq_valid = 1'b1; seq_freq = 29'd22222; pad_req = 4'b0010;
        #1;
        chk("seq_ready_blocked", 32'(seq_ready), 32'd0);
        step(1); pad_req = 4'b0000;
        c = 0;
        while (accepts == ab && c < 40) begin
            step(1); c++;
        end
        seq_valid = 1'b0;
        wait_idle("mix", 60);
        chk_note("mix_pad", nb, 8, 75842, 1);
        chk_note("mix_seq", nb + 1, 8, 22222, 4);
        chk("mix_accepts", 32'(accepts - ab), 32'd1);

        // Pad 3 pressed while a sequencer note is at dur=3
        nb = len_q.size(); gb = gap_q.size();
        seq_valid = 1'b1; seq_freq = 29'd33333;
        step(1); seq_valid = 1'b0;
        step(3);
        pad_req = 4'b1000;
        c = 0;
        while (!(tone_en && active_src == 3'd3) && c < 60) begin
            step(1); c++;
        end
        pad_req = 4'b0000;
        wait_idle("pre", 60);
`ifdef TONE_SCHED_PREEMPT_EN
        chk_note("pre_seq", nb, 4, 33333, 4);
`else
        chk_note("pre_seq", nb, 8, 33333, 4);
`endif
        chk_gap("pre_gap", gb);
        chk_note("pre_pad", nb + 1, 8, 47777, 3);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish before 200000");
        $fatal(1, "global timeout");
    end

endmodule
